host_port: RTL and testbench

Host-side bus interface for the text-mode VRAM, acting as the writer and host reader opposite the display readout. It accepts a slow asynchronous 8-bit microcontroller bus (chip select, read and write strobes, 2-bit register select) and turns register accesses into single-cycle VRAM host-port transactions. It drives `hostAddr`, `hostWrData`, `hostSelect` and `hostRd`, and consumes `hostRdData`. A 13-bit auto-incrementing address pointer gives sequential character and attribute fills.

---
 rtl/host_port.sv | 227 ++++++++++++++++++++++
 tb/tb_host_port.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/host_port.sv
// ============================================================================
//  Module      : host_port
//  Description : Host-side microcontroller bus bridge for the text-mode VRAM.
//                Synchronises an asynchronous 8-bit strobe bus, maintains an
//                auto-incrementing VRAM pointer and turns register accesses
//                into single-cycle VRAM host-port write/read transactions.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module host_port #(
  // Supported range: 9..16 (pointer high byte covers ptr[ADDR_W-1:8]).
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              busNcs,
  input  logic              busNwr,
  input  logic              busNrd,
  input  logic [1:0]        busRs,
  input  logic [7:0]        busDataIn,
  output logic [7:0]        busDataOut,
  output logic              busDataOe,
  output logic [ADDR_W-1:0] hostAddr,
  output logic [7:0]        hostWrData,
  output logic              hostSelect,
  output logic              hostRd,
  input  logic [7:0]        hostRdData
);

  localparam logic [1:0] RS_ADDR_LO = 2'd0;
  localparam logic [1:0] RS_ADDR_HI = 2'd1;
  localparam logic [1:0] RS_DATA    = 2'd2;
  localparam logic [1:0] RS_STATUS  = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    PREFETCH = 2'd2,
    CAPTURE  = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [7:0]        read_latch;
  logic              overrun;
  logic              busy;

  // Strobe synchronisers and edge-detect history
  logic ncs_meta, ncs_sync;
  logic nwr_meta, nwr_sync;
  logic nrd_meta, nrd_sync;
  logic wr_prev, rd_prev;
  logic [1:0] rd_rs;       // register select captured at the start of a read
  logic rd_blocked;        // read overlapped a write strobe: write wins

  logic wr_n, rd_n;
  logic wr_evt, rd_start, rd_evt;

  logic [ADDR_W-1:0] ptr_lo_load;
  logic [ADDR_W-1:0] ptr_hi_load;
  logic [ADDR_W-1:0] ptr_inc;
  logic [7:0]        ptr_hi_byte;

  assign wr_n     = ncs_sync | nwr_sync;
  assign rd_n     = ncs_sync | nrd_sync;
  assign wr_evt   = wr_prev & ~wr_n;
  assign rd_start = rd_prev & ~rd_n;
  assign rd_evt   = ~rd_prev & rd_n & ~rd_blocked;

  assign busy      = (state != IDLE);
  assign hostAddr  = ptr;
  assign busDataOe = ~busNcs & ~busNrd & busNwr;
  assign ptr_inc   = ptr + 1'b1;

  // Pointer load values for the low/high address registers and the high byte readback
  always_comb begin
    ptr_lo_load                = ptr;
    ptr_lo_load[7:0]           = busDataIn;
    ptr_hi_load                = ptr;
    ptr_hi_load[ADDR_W-1:8]    = busDataIn[ADDR_W-9:0];
    ptr_hi_byte                = '0;
    ptr_hi_byte[ADDR_W-9:0]    = ptr[ADDR_W-1:8];
  end

  // Host read mux, driven from the live register select
  always_comb begin
    busDataOut = 8'h00;
    case (busRs)
      RS_ADDR_LO: busDataOut = ptr[7:0];
      RS_ADDR_HI: busDataOut = ptr_hi_byte;
      RS_DATA:    busDataOut = read_latch;
      RS_STATUS:  busDataOut = {6'b0, overrun, busy};
      default:    busDataOut = 8'h00;
    endcase
  end

  // Two-flop synchronisers, previous-value registers and read context capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ncs_meta   <= 1'b1;
      ncs_sync   <= 1'b1;
      nwr_meta   <= 1'b1;
      nwr_sync   <= 1'b1;
      nrd_meta   <= 1'b1;
      nrd_sync   <= 1'b1;
      wr_prev    <= 1'b1;
      rd_prev    <= 1'b1;
      rd_rs      <= 2'd0;
      rd_blocked <= 1'b0;
    end else begin
      ncs_meta <= busNcs;
      ncs_sync <= ncs_meta;
      nwr_meta <= busNwr;
      nwr_sync <= nwr_meta;
      nrd_meta <= busNrd;
      nrd_sync <= nrd_meta;
      wr_prev  <= wr_n;
      rd_prev  <= rd_n;
      // Register select is captured while the raw strobe is still held, since
      // the read side effect only fires after the host has released the bus.
      if (rd_start) begin
        rd_rs      <= busRs;
        rd_blocked <= ~wr_n;
      end else if (~rd_n) begin
        rd_blocked <= rd_blocked | ~wr_n;
      end
    end
  end

  // Access FSM: pointer, VRAM strobes, read latch and sticky overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      hostWrData <= 8'h00;
      hostSelect <= 1'b0;
      hostRd     <= 1'b1;
      read_latch <= 8'h00;
      overrun    <= 1'b0;
    end else begin
      // Events landing while busy are dropped; only a status read is honoured.
      if (busy) begin
        if (wr_evt) begin
          overrun <= 1'b1;
        end else if (rd_evt) begin
          overrun <= (rd_rs != RS_STATUS);
        end
      end

      case (state)
        IDLE: begin
          hostSelect <= 1'b0;
          hostRd     <= 1'b1;
          if (wr_evt) begin
            case (busRs)
              RS_ADDR_LO: begin
                ptr        <= ptr_lo_load;
                hostSelect <= 1'b1;
                hostRd     <= 1'b1;
                state      <= PREFETCH;
              end
              RS_ADDR_HI: begin
                ptr        <= ptr_hi_load;
                hostSelect <= 1'b1;
                hostRd     <= 1'b1;
                state      <= PREFETCH;
              end
              RS_DATA: begin
                hostWrData <= busDataIn;
                hostSelect <= 1'b1;
                hostRd     <= 1'b0;
                state      <= WRITE;
              end
              default: begin
                state <= IDLE;
              end
            endcase
          end else if (rd_evt) begin
            case (rd_rs)
              RS_DATA: begin
                ptr        <= ptr_inc;
                hostSelect <= 1'b1;
                hostRd     <= 1'b1;
                state      <= PREFETCH;
              end
              RS_STATUS: begin
                overrun <= 1'b0;
              end
              default: begin
                state <= IDLE;
              end
            endcase
          end
        end

        WRITE: begin
          // Write strobe is done this edge; advance and prefetch the next cell.
          ptr        <= ptr_inc;
          hostSelect <= 1'b1;
          hostRd     <= 1'b1;
          state      <= PREFETCH;
        end

        PREFETCH: begin
          hostSelect <= 1'b0;
          hostRd     <= 1'b1;
          state      <= CAPTURE;
        end

        CAPTURE: begin
          read_latch <= hostRdData;
          state      <= IDLE;
        end

        default: begin
          hostSelect <= 1'b0;
          hostRd     <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_host_port.sv
// ============================================================================
//  Module      : tb_host_port
//  Description : Directed self-checking bench for host_port with a VRAM model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_host_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busNcs = 1'b1;
  logic        busNwr = 1'b1;
  logic        busNrd = 1'b1;
  logic [1:0]  busRs = 2'd0;
  logic [7:0]  busDataIn = 8'h00;
  logic [7:0]  busDataOut;
  logic        busDataOe;
  logic [12:0] hostAddr;
  logic [7:0]  hostWrData;
  logic        hostSelect;
  logic        hostRd;
  logic [7:0]  hostRdData;

  host_port #(.ADDR_W(13)) dut (
    .clk        (clk),
    .rst        (rst),
    .busNcs     (busNcs),
    .busNwr     (busNwr),
    .busNrd     (busNrd),
    .busRs      (busRs),
    .busDataIn  (busDataIn),
    .busDataOut (busDataOut),
    .busDataOe  (busDataOe),
    .hostAddr   (hostAddr),
    .hostWrData (hostWrData),
    .hostSelect (hostSelect),
    .hostRd     (hostRd),
    .hostRdData (hostRdData)
  );

  always #5 clk = ~clk;

  // VRAM model: cell i powers up as i[7:0] ^ 8'hA5
  logic [7:0] mem [0:8191];
  bit         mem_done = 1'b0;
  logic [7:0] rdq = 8'h00;
  assign hostRdData = rdq;

  always @(posedge clk) begin
    if (!mem_done) begin
      for (int i = 0; i < 8192; i++) begin
        mem[i] <= 8'(i) ^ 8'hA5;
      end
      mem_done <= 1'b1;
    end else begin
      if (hostSelect && !hostRd) mem[hostAddr] <= hostWrData;
      if (hostSelect && hostRd)  rdq <= mem[hostAddr];
    end
  end

  // Transaction monitor, sampled 1 time unit after each rising edge
  typedef struct {
    int         cyc;
    logic [12:0] addr;
    logic [7:0]  data;
  } wrec_t;

  wrec_t       wr_q[$];
  logic [12:0] rd_q[$];
  int          cyc = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (hostSelect && !hostRd) wr_q.push_back('{cyc, hostAddr, hostWrData});
    if (hostSelect && hostRd)  rd_q.push_back(hostAddr);
  end

  int n_cmp = 0;
  int n_err = 0;
  int last_e0 = 0;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Peek a register through the live read mux without issuing a bus read
  task automatic peek(input logic [1:0] rs, output logic [7:0] d);
    busRs = rs;
    #1;
    d = busDataOut;
  endtask

  task automatic bus_write(input logic [1:0] rs, input logic [7:0] d);
    @(negedge clk);
    busRs = rs; busDataIn = d; busNcs = 1'b0; busNwr = 1'b0;
    @(posedge clk); #1;
    last_e0 = cyc;
    repeat (5) @(negedge clk);
    busNcs = 1'b1; busNwr = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic bus_read(input logic [1:0] rs, output logic [7:0] d, output logic oe);
    @(negedge clk);
    busRs = rs; busNcs = 1'b0; busNrd = 1'b0;
    repeat (4) @(negedge clk);
    d  = busDataOut;
    oe = busDataOe;
    busNcs = 1'b1; busNrd = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  logic [7:0] v;
  logic       oe;
  bit         found;

  initial begin
    // ---------------- reset values ----------------
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_val("rst_hostSelect", 16'(hostSelect), 16'h1 ^ 16'h1);
    check_val("rst_hostRd", 16'(hostRd), 16'h1);
    check_val("rst_hostAddr", 16'(hostAddr), 16'h0000);
    check_val("rst_hostWrData", 16'(hostWrData), 16'h00);
    peek(2'd0, v); check_val("rst_rs0", 16'(v), 16'h00);
    peek(2'd1, v); check_val("rst_rs1", 16'(v), 16'h00);
    peek(2'd2, v); check_val("rst_rs2", 16'(v), 16'h00);
    peek(2'd3, v); check_val("rst_status", 16'(v), 16'h00);
    check_val("rst_no_prefetch", 16'(rd_q.size()), 16'd0);
    check_val("rst_oe_idle", 16'(busDataOe), 16'h0);

    // ---------------- reset mid-WRITE ----------------
    @(negedge clk);
    busRs = 2'd2; busDataIn = 8'h77; busNcs = 1'b0; busNwr = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      if (hostSelect && !hostRd) found = 1'b1;
    end
    check_val("midwr_seen", 16'(found), 16'h1);
    #2 rst = 1'b1;
    #1;
    check_val("midwr_sel_drop", 16'(hostSelect), 16'h0);
    check_val("midwr_rd_high", 16'(hostRd), 16'h1);
    busNcs = 1'b1; busNwr = 1'b1;
    wr_q.delete(); rd_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    peek(2'd0, v); check_val("midwr_ptr_lo", 16'(v), 16'h00);
    peek(2'd3, v); check_val("midwr_status", 16'(v), 16'h00);
    check_val("midwr_mem0", 16'(mem[0]), 16'h00A5);
    check_val("midwr_no_wr", 16'(wr_q.size()), 16'd0);
    check_val("midwr_no_prefetch", 16'(rd_q.size()), 16'd0);

    // ---------------- pointer load and prefetch ----------------
    bus_write(2'd0, 8'h34);
    rd_q.delete();
    bus_write(2'd1, 8'hF2);
    peek(2'd0, v); check_val("ptr_lo", 16'(v), 16'h34);
    peek(2'd1, v); check_val("ptr_hi", 16'(v), 16'h12);
    check_val("ptr_prefetch_cnt", 16'(rd_q.size()), 16'd1);
    if (rd_q.size() > 0) check_val("ptr_prefetch_addr", 16'(rd_q[0]), 16'h1234);
    peek(2'd2, v); check_val("ptr_latch", 16'(v), 16'h91);

    // ---------------- fill ----------------
    bus_write(2'd0, 8'h10);
    bus_write(2'd1, 8'h00);
    begin
      logic [7:0] fill [3] = '{8'h41, 8'h1F, 8'h42};
      for (int k = 0; k < 3; k++) begin
        wr_q.delete();
        bus_write(2'd2, fill[k]);
        check_val("fill_wr_cnt", 16'(wr_q.size()), 16'd1);
        if (wr_q.size() > 0) begin
          check_val("fill_wr_lat", 16'(wr_q[0].cyc - last_e0), 16'd2);
          check_val("fill_wr_addr", 16'(wr_q[0].addr), 16'(16'h0010 + 16'(k)));
        end
      end
    end
    check_val("fill_mem10", 16'(mem[16'h10]), 16'h41);
    check_val("fill_mem11", 16'(mem[16'h11]), 16'h1F);
    check_val("fill_mem12", 16'(mem[16'h12]), 16'h42);
    peek(2'd0, v); check_val("fill_ptr", 16'(v), 16'h13);
    peek(2'd2, v); check_val("fill_latch", 16'(v), 16'hB6);

    // ---------------- readback ----------------
    bus_write(2'd0, 8'h10);
    bus_read(2'd2, v, oe); check_val("rb_0", 16'(v), 16'h41);
    check_val("rb_oe", 16'(oe), 16'h1);
    bus_read(2'd2, v, oe); check_val("rb_1", 16'(v), 16'h1F);
    bus_read(2'd2, v, oe); check_val("rb_2", 16'(v), 16'h42);
    peek(2'd0, v); check_val("rb_ptr", 16'(v), 16'h13);

    // ---------------- wrap ----------------
    bus_write(2'd0, 8'hFF);
    bus_write(2'd1, 8'h1F);
    peek(2'd1, v); check_val("wrap_ptr_hi_pre", 16'(v), 16'h1F);
    rd_q.delete();
    bus_write(2'd2, 8'h55);
    check_val("wrap_mem", 16'(mem[16'h1FFF]), 16'h55);
    peek(2'd0, v); check_val("wrap_ptr_lo", 16'(v), 16'h00);
    peek(2'd1, v); check_val("wrap_ptr_hi", 16'(v), 16'h00);
    check_val("wrap_prefetch_cnt", 16'(rd_q.size()), 16'd1);
    if (rd_q.size() > 0) check_val("wrap_prefetch_addr", 16'(rd_q[0]), 16'h0000);
    peek(2'd2, v); check_val("wrap_latch", 16'(v), 16'hA5);

    // ---------------- overrun ----------------
    bus_write(2'd0, 8'h20);
    wr_q.delete();
    @(negedge clk);
    busRs = 2'd2; busDataIn = 8'hAA; busNcs = 1'b0; busNwr = 1'b0;
    repeat (2) @(negedge clk);
    busNcs = 1'b1; busNwr = 1'b1;
    @(negedge clk);
    busDataIn = 8'hBB; busNcs = 1'b0; busNwr = 1'b0;
    repeat (5) @(negedge clk);
    busNcs = 1'b1; busNwr = 1'b1;
    repeat (10) @(negedge clk);
    check_val("ovr_wr_cnt", 16'(wr_q.size()), 16'd1);
    check_val("ovr_mem20", 16'(mem[16'h20]), 16'hAA);
    check_val("ovr_mem21", 16'(mem[16'h21]), 16'h84);
    peek(2'd0, v); check_val("ovr_ptr", 16'(v), 16'h21);
    peek(2'd3, v); check_val("ovr_status", 16'(v), 16'h02);
    bus_read(2'd3, v, oe); check_val("ovr_status_rd", 16'(v), 16'h02);
    peek(2'd3, v); check_val("ovr_cleared", 16'(v), 16'h00);

    // ---------------- simultaneous write and read strobes ----------------
    bus_write(2'd0, 8'h30);
    @(negedge clk);
    busRs = 2'd2; busDataIn = 8'h66; busNcs = 1'b0; busNwr = 1'b0; busNrd = 1'b0;
    repeat (2) @(negedge clk);
    check_val("both_oe", 16'(busDataOe), 16'h0);
    repeat (3) @(negedge clk);
    busNcs = 1'b1; busNwr = 1'b1; busNrd = 1'b1;
    repeat (12) @(negedge clk);
    check_val("both_mem30", 16'(mem[16'h30]), 16'h66);
    peek(2'd0, v); check_val("both_ptr", 16'(v), 16'h31);
    peek(2'd3, v); check_val("both_status", 16'(v), 16'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
